// File: rtl/data_mem_master.sv
// data_mem_master: CPU load/store requests to data_mem transactions.
// Ports: clk/reset (sync, active-low); req_* valid/ready request from the MEM stage;
// resp_valid/resp_rdata/resp_err one-cycle response; mem_* drive data_mem, mem_rdata
// is its combinational read data. Sub-dword stores become one byte write per cycle.
module data_mem_master #(
  parameter logic [63:0] DATA_START = 64'h10000000,
  parameter logic [63:0] DATA_BYTES = 64'h8000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_word_we,
  output logic        mem_byte_we,
  input  logic [63:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, LOAD, STORE, RESP} state_t;
  state_t state;
  logic [63:0] addr, wdata, sh, ext, nbyte;
  logic [1:0]  size, k, nk;
  logic        sgn, last, bad;
  logic [2:0]  mask;
  logic [64:0] req_end, lim;
  assign req_ready = state == IDLE;
  always_comb begin
    mask    = 3'((4'd1 << req_size) - 4'd1);
    req_end = {1'b0, req_addr} + (65'd1 << req_size);
    lim     = {1'b0, DATA_START} + {1'b0, DATA_BYTES};
    bad     = |(req_addr[2:0] & mask) || req_addr < DATA_START || req_end > lim;
    sh      = mem_rdata >> {addr[2:0], 3'b000};
    ext     = size == 2'd0 ? {{56{sgn & sh[7]}}, sh[7:0]} :
              size == 2'd1 ? {{48{sgn & sh[15]}}, sh[15:0]} :
              size == 2'd2 ? {{32{sgn & sh[31]}}, sh[31:0]} : sh;
    nk      = k + 2'd1;
    nbyte   = wdata >> {nk, 3'b000};
    // last byte index of a sub-dword store: 0 for byte, 1 for half, 3 for word32
    last    = k == (size == 2'd2 ? 2'd3 : {1'b0, size[0]});
  end
  // Outputs are loaded one edge early so every strobe is a clean register output
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      addr        <= '0;
      wdata       <= '0;
      size        <= '0;
      sgn         <= 1'b0;
      k           <= '0;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      resp_rdata  <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_word_we <= 1'b0;
      mem_byte_we <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          addr  <= req_addr;
          wdata <= req_wdata;
          size  <= req_size;
          sgn   <= req_signed;
          k     <= '0;
          if (bad) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
          end else if (!req_we) begin
            state    <= LOAD;
            mem_addr <= {req_addr[63:3], 3'b000};
          end else begin
            state       <= STORE;
            mem_word_we <= req_size == 2'd3;
            mem_byte_we <= req_size != 2'd3;
            mem_addr    <= req_size == 2'd3 ? {req_addr[63:3], 3'b000} : req_addr;
            mem_wdata   <= req_size == 2'd3 ? req_wdata : {56'b0, req_wdata[7:0]};
          end
        end
        LOAD: begin
          state      <= RESP;
          resp_rdata <= ext;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
        end
        STORE: if (size == 2'd3 || last) begin
          state       <= RESP;
          mem_word_we <= 1'b0;
          mem_byte_we <= 1'b0;
          resp_valid  <= 1'b1;
          resp_err    <= 1'b0;
        end else begin
          k         <= nk;
          mem_addr  <= addr + {62'b0, nk};
          mem_wdata <= {56'b0, nbyte[7:0]};
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_master.sv
// tb_data_mem_master: directed self-checking bench for data_mem_master with a byte-array data_mem.
module tb_data_mem_master;
  logic        clk = 1'b0, reset = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = '0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid, resp_err, mem_word_we, mem_byte_we;
  logic [63:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  dmem [0:127];
  int          checks = 0, failures = 0, both_we = 0;
  int          lat, nw, nb;
  logic        err, sres;
  logic [63:0] rd;
  logic [63:0] la [0:7];
  logic [63:0] ldat [0:7];

  data_mem_master dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_word_we(mem_word_we), .mem_byte_we(mem_byte_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 128; i++) dmem[i] = 8'h00;

  always_comb begin
    mem_rdata = '0;
    for (int i = 0; i < 8; i++) mem_rdata[8*i +: 8] = dmem[{mem_addr[6:3], 3'(i)}];
  end

  always @(negedge clk) begin
    if (mem_word_we && mem_byte_we) both_we++;
    if (mem_word_we) for (int i = 0; i < 8; i++) dmem[{mem_addr[6:3], 3'(i)}] <= mem_wdata[8*i +: 8];
    if (mem_byte_we) dmem[mem_addr[6:0]] <= mem_wdata[7:0];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request from IDLE, follow it to its response, then return to IDLE.
  task automatic xact(input logic we, input logic [1:0] sz, input logic sg,
                      input logic [63:0] a, input logic [63:0] wd);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; nw = 0; nb = 0;
    while (!resp_valid && lat < 20) begin
      if (mem_byte_we && nb < 8) begin la[nb] = mem_addr; ldat[nb] = mem_wdata; end
      nw += int'(mem_word_we);
      nb += int'(mem_byte_we);
      @(posedge clk); #1;
      lat++;
    end
    err = resp_err; rd = resp_rdata; sres = mem_word_we | mem_byte_we;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_rdata", resp_rdata, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_strobes", {62'd0, mem_word_we, mem_byte_we}, 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", 64'(req_ready), 64'd1);

    xact(1'b1, 2'd3, 1'b0, 64'h10000008, 64'h1122334455667788);
    chk("sd_lat", 64'(lat), 64'd2);
    chk("sd_err", 64'(err), 64'd0);
    chk("sd_word_we", 64'(nw), 64'd1);
    chk("sd_byte_we", 64'(nb), 64'd0);

    xact(1'b0, 2'd0, 1'b1, 64'h10000008, 64'h0);
    chk("lb_s", rd, 64'hFFFFFFFFFFFFFF88);
    chk("lb_s_lat", 64'(lat), 64'd2);
    xact(1'b0, 2'd0, 1'b0, 64'h10000008, 64'h0);
    chk("lb_u", rd, 64'h0000000000000088);
    xact(1'b0, 2'd1, 1'b1, 64'h1000000E, 64'h0);
    chk("lh_s", rd, 64'h0000000000001122);
    chk("lh_lat", 64'(lat), 64'd2);
    chk("lh_strobes", 64'(nw + nb), 64'd0);

    xact(1'b1, 2'd2, 1'b0, 64'h1000000C, 64'h00000000DEADBEEF);
    chk("sw_lat", 64'(lat), 64'd5);
    chk("sw_byte_we", 64'(nb), 64'd4);
    chk("sw_word_we", 64'(nw), 64'd0);
    chk("sw_resp_strobe", 64'(sres), 64'd0);
    chk("sw_a0", la[0], 64'h1000000C); chk("sw_d0", ldat[0], 64'hEF);
    chk("sw_a1", la[1], 64'h1000000D); chk("sw_d1", ldat[1], 64'hBE);
    chk("sw_a2", la[2], 64'h1000000E); chk("sw_d2", ldat[2], 64'hAD);
    chk("sw_a3", la[3], 64'h1000000F); chk("sw_d3", ldat[3], 64'hDE);
    xact(1'b0, 2'd3, 1'b0, 64'h10000008, 64'h0);
    chk("ld_merge", rd, 64'hDEADBEEF55667788);
    xact(1'b0, 2'd2, 1'b1, 64'h1000000C, 64'h0);
    chk("lw_s", rd, 64'hFFFFFFFFDEADBEEF);

    xact(1'b1, 2'd1, 1'b0, 64'h10000001, 64'h1234);
    chk("sh_mis_err", 64'(err), 64'd1);
    chk("sh_mis_lat", 64'(lat), 64'd1);
    chk("sh_mis_strobes", 64'(nw + nb), 64'd0);
    chk("sh_mis_mem", 64'(dmem[1]), 64'd0);
    xact(1'b0, 2'd3, 1'b0, 64'h0FFFFFF8, 64'h0);
    chk("ld_low_err", 64'(err), 64'd1);
    chk("ld_low_lat", 64'(lat), 64'd1);
    xact(1'b0, 2'd3, 1'b0, 64'h10008000, 64'h0);
    chk("ld_high_err", 64'(err), 64'd1);
    xact(1'b0, 2'd3, 1'b0, 64'h10007FF8, 64'h0);
    chk("ld_last_err", 64'(err), 64'd0);
    chk("ld_last_lat", 64'(lat), 64'd2);
    xact(1'b0, 2'd2, 1'b0, 64'h10007FFE, 64'h0);
    chk("lw_mis_err", 64'(err), 64'd1);

    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 64'h10000010; req_wdata = 64'hAABBCCDD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_ready", 64'(req_ready), 64'd1);
    chk("rstmid_resp", 64'(resp_valid), 64'd0);
    chk("rstmid_strobes", {62'd0, mem_word_we, mem_byte_we}, 64'd0);
    reset = 1'b1;
    nw = 0;
    repeat (3) begin @(posedge clk); #1; nw += int'(resp_valid); end
    chk("rstmid_noresp", 64'(nw), 64'd0);
    chk("rstmid_b0", 64'(dmem[8'h10]), 64'hDD);
    chk("rstmid_b1", 64'(dmem[8'h11]), 64'hCC);
    chk("rstmid_b2", 64'(dmem[8'h12]), 64'h00);
    chk("rstmid_b3", 64'(dmem[8'h13]), 64'h00);
    xact(1'b0, 2'd2, 1'b0, 64'h10000010, 64'h0);
    chk("rstmid_lw", rd, 64'h000000000000CCDD);

    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd3; req_signed = 1'b0;
    req_addr = 64'h10000018; req_wdata = 64'hCAFE;
    @(posedge clk); #1;
    req_we = 1'b0; req_wdata = 64'h5555; req_size = 2'd3;
    chk("bp_ready_s1", 64'(req_ready), 64'd0);
    chk("bp_word_s1", 64'(mem_word_we), 64'd1);
    @(posedge clk); #1;
    chk("bp_ready_s2", 64'(req_ready), 64'd0);
    chk("bp_resp_a", 64'(resp_valid), 64'd1);
    @(posedge clk); #1;
    chk("bp_ready_s3", 64'(req_ready), 64'd1);
    chk("bp_idle_quiet", {62'd0, resp_valid, mem_word_we}, 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp_ready_s4", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    chk("bp_resp_b", 64'(resp_valid), 64'd1);
    chk("bp_rdata_b", resp_rdata, 64'hCAFE);
    @(posedge clk); #1;
    chk("both_we_never", 64'(both_we), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
